// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: IF/DM requester ports, memory port and status of mem_arbiter.
// slave is the arbiter side, master the pipeline/memory environment side.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          if_req;
   logic [AW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_ack;
   logic          dm_req;
   logic          dm_we;
   logic [AW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_ack;
   logic          if_stall;
   logic          dm_stall;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;
   logic [1:0]    grant;
   logic          arb_err;
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      output if_rdata, if_ack, dm_rdata, dm_ack, if_stall, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, grant, arb_err
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
      input  if_rdata, if_ack, dm_rdata, dm_ack, if_stall, dm_stall,
             mem_req, mem_we, mem_addr, mem_wdata, grant, arb_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: serializes IF fetches and MEM loads/stores onto one single-port memory.
// Define MEMARB_RR_EN for round-robin arbitration; default is fixed DM-over-IF priority.
module mem_arbiter #(
   parameter int AW       = 32,
   parameter int DW       = 32,
   parameter int MAX_WAIT = 15
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t        state, state_nx;
   logic [7:0]    wait_cnt;
   logic          last_dm;
   logic          pick_dm, start, done, timeout;
   logic [AW-1:0] sel_addr;
   logic [DW-1:0] rd_val;
`ifdef MEMARB_RR_EN
   assign pick_dm = bus.dm_req & (~bus.if_req | ~last_dm);
`else
   assign pick_dm = bus.dm_req;
`endif
   assign start        = (state == IDLE) & (bus.if_req | bus.dm_req);
   assign done         = (state == ISSUE) & bus.mem_ready;
   assign timeout      = (state == ISSUE) & ~bus.mem_ready & (wait_cnt == 8'(MAX_WAIT));
   assign sel_addr     = pick_dm ? bus.dm_addr : bus.if_addr;
   assign rd_val       = done ? bus.mem_rdata : '0;
   assign bus.if_ack   = (state == RESP) & bus.grant[0];
   assign bus.dm_ack   = (state == RESP) & bus.grant[1];
   assign bus.if_stall = bus.if_req & ~bus.if_ack;
   assign bus.dm_stall = bus.dm_req & ~bus.dm_ack;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    state_nx = start ? ISSUE : IDLE;
         ISSUE:   state_nx = (done | timeout) ? RESP : ISSUE;
         default: state_nx = IDLE;
      endcase
   end
   // mem_we still reflects the in-flight transaction when it completes, so it selects read capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.mem_req   <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.if_rdata  <= '0;
         bus.dm_rdata  <= '0;
         bus.grant     <= 2'b00;
         bus.arb_err   <= 1'b0;
         last_dm       <= 1'b0;
         wait_cnt      <= '0;
      end else begin
         if (start) begin
            bus.mem_req  <= 1'b1;
            bus.mem_we   <= pick_dm & bus.dm_we;
            bus.mem_addr <= sel_addr;
            bus.grant    <= pick_dm ? 2'b10 : 2'b01;
            last_dm      <= pick_dm;
            wait_cnt     <= '0;
            if (pick_dm) bus.mem_wdata <= bus.dm_wdata;
         end
         if ((state == ISSUE) && !(done | timeout)) wait_cnt <= wait_cnt + 8'd1;
         if (done | timeout) begin
            bus.mem_req <= 1'b0;
            bus.mem_we  <= 1'b0;
            if (!bus.mem_we && bus.grant[0]) bus.if_rdata <= rd_val;
            if (!bus.mem_we && bus.grant[1]) bus.dm_rdata <= rd_val;
         end
         if (timeout) bus.arb_err <= 1'b1;
         if (state == RESP) bus.grant <= 2'b00;
      end
   end
endmodule
